// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID pipeline buffer. A DEPTH-entry circular instruction queue
// feeds a registered decode-side output stage, letting fetch run ahead while
// decode stalls. An EX-resolved branch flushes the queue and the output stage.
//
// Optional feature macro: IFQ_BYPASS_EN
//   defined   -> with an empty queue and no stall, an accepted instruction goes
//                straight to the output stage (1-cycle latency).
//   undefined -> every accepted instruction is queued first (2-cycle latency).
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   if_flag        IF presents a valid instruction
//   if_pc/if_inst  presented PC / instruction word
//   if_full        queue full, IF must hold (combinational from count)
//   id_stall       ID holding; output stage does not advance
//   branch_from_ex flush request from EX
//   id_flag        output stage holds a valid instruction
//   id_pc/id_inst  PC / instruction to ID
//   ifq_count      registered queue occupancy
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_flag,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_full,
  input  logic                     id_stall,
  input  logic                     branch_from_ex,
  output logic                     id_flag,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   ifq_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0]  count, count_next;

  logic              flag_next;
  logic [ADDR_W-1:0] pc_next;
  logic [INST_W-1:0] inst_next;

  logic              push;
  logic              pop;
  logic              bypass;
  logic              push_q;

  // Full is taken from the pre-edge count, so a full queue rejects a push
  // even when a pop happens in the same cycle.
  assign if_full   = (count == CNT_W'(DEPTH));
  assign ifq_count = count;

  // Handshake decode: flush suppresses both push and pop.
  always_comb begin
    push = if_flag & ~if_full & ~branch_from_ex;
    pop  = ~id_stall & (count != '0) & ~branch_from_ex;
`ifdef IFQ_BYPASS_EN
    bypass = push & ~id_stall & (count == '0);
`else
    bypass = 1'b0;
`endif
    push_q = push & ~bypass;
  end

  // Next-state for pointers, occupancy and the output stage.
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    flag_next   = id_flag;
    pc_next     = id_pc;
    inst_next   = id_inst;

    if (branch_from_ex) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      flag_next   = 1'b0;
      pc_next     = '0;
      inst_next   = '0;
    end else begin
      if (push_q) wr_ptr_next = wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr_next = rd_ptr + PTR_W'(1);
      count_next = count + CNT_W'(push_q) - CNT_W'(pop);

      // Output advances only when ID is not stalled; no source means bubble.
      if (!id_stall) begin
        if (pop) begin
          flag_next = 1'b1;
          pc_next   = mem_pc[rd_ptr];
          inst_next = mem_inst[rd_ptr];
        end else if (bypass) begin
          flag_next = 1'b1;
          pc_next   = if_pc;
          inst_next = if_inst;
        end else begin
          flag_next = 1'b0;
          pc_next   = '0;
          inst_next = '0;
        end
      end
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      id_flag <= 1'b0;
      id_pc   <= '0;
      id_inst <= '0;
    end else begin
      rd_ptr  <= rd_ptr_next;
      wr_ptr  <= wr_ptr_next;
      count   <= count_next;
      id_flag <= flag_next;
      id_pc   <= pc_next;
      id_inst <= inst_next;
    end
  end

  // Queue storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push_q) begin
      mem_pc[wr_ptr]   <= if_pc;
      mem_inst[wr_ptr] <= if_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4). Stimulus pushes the expected
// output of every instruction that must reach ID into a scoreboard; a monitor
// pops and compares whenever the output stage advances with a valid entry.
module tb_if_id_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_flag = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_full;
  logic        id_stall = 1'b0;
  logic        branch_from_ex = 1'b0;
  logic        id_flag;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  ifq_count;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  ent_t mon_e;
  logic mon_adv;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .if_flag(if_flag), .if_pc(if_pc), .if_inst(if_inst),
    .if_full(if_full), .id_stall(id_stall), .branch_from_ex(branch_from_ex),
    .id_flag(id_flag), .id_pc(id_pc), .id_inst(id_inst), .ifq_count(ifq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; acc=1 queues the entry as an expected ID output.
  task automatic step(input logic f, input logic [31:0] pc, input logic st,
                      input logic br, input logic acc);
    @(negedge clk);
    if_flag        = f;
    if_pc          = pc;
    if_inst        = inst_of(pc);
    id_stall       = st;
    branch_from_ex = br;
    if (acc) exp_q.push_back('{pc: pc, inst: inst_of(pc)});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 32'h0, st, 1'b0, 1'b0);
  endtask

  // Monitor: the output stage loads a new entry at every un-stalled, un-flushed edge.
  always @(posedge clk) begin
    mon_adv = rst && !id_stall && !branch_from_ex;
    #1;
    if (mon_adv && rst && id_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got_pc=%h want=none", id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (id_pc !== mon_e.pc || id_inst !== mon_e.inst) begin
          errors++;
          $display("FAIL order got_pc=%h got_inst=%h want_pc=%h want_inst=%h",
                   id_pc, id_inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_flag", 32'(id_flag), 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_count", 32'(ifq_count), 32'h0);
    chk("rst_full", 32'(if_full), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming 0x0,0x4,0x8 with no stall
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("str1_flag", 32'(id_flag), BYP ? 32'h1 : 32'h0);
    chk("str1_count", 32'(ifq_count), BYP ? 32'h0 : 32'h1);
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    chk("str2_pc", id_pc, BYP ? 32'h4 : 32'h0);
    chk("str2_count", 32'(ifq_count), BYP ? 32'h0 : 32'h1);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    chk("str3_pc", id_pc, BYP ? 32'h8 : 32'h4);
    idle(1'b0);
    chk("str4_flag", 32'(id_flag), BYP ? 32'h0 : 32'h1);
    idle(1'b0);
    chk("str5_flag", 32'(id_flag), 32'h0);
    chk("str5_count", 32'(ifq_count), 32'h0);

    // Stall fill to full; fifth push dropped
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
      chk("fill_count", 32'(ifq_count), 32'(i + 1));
    end
    chk("fill_full", 32'(if_full), 32'h1);
    chk("fill_hold_flag", 32'(id_flag), 32'h0);
    step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
    chk("drop_count", 32'(ifq_count), 32'h4);
    chk("drop_full", 32'(if_full), 32'h1);
    idle(1'b0);
    chk("rel_pc", id_pc, 32'h10);
    chk("rel_count", 32'(ifq_count), 32'h3);
    chk("rel_full", 32'(if_full), 32'h0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("drain_pc", id_pc, 32'h1C);
    idle(1'b0);
    chk("drain_flag", 32'(id_flag), 32'h0);
    chk("drain_count", 32'(ifq_count), 32'h0);

    // Wrap-around: count held at 2 for 10 push/pop cycles
    step(1'b1, 32'hA0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hA4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hA8 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
      chk("wrap_count", 32'(ifq_count), 32'h2);
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("wrap_end_flag", 32'(id_flag), 32'h0);
    chk("wrap_end_count", 32'(ifq_count), 32'h0);

    // Flush with a simultaneous push: count=3, id_flag=1
    step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hC4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hC8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_flush_flag", 32'(id_flag), 32'h1);
    chk("pre_flush_count", 32'(ifq_count), 32'h3);
    step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    chk("flush_flag", 32'(id_flag), 32'h0);
    chk("flush_pc", id_pc, 32'h0);
    chk("flush_count", 32'(ifq_count), 32'h0);
    step(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    chk("post_flush_count", 32'(ifq_count), BYP ? 32'h0 : 32'h1);
    chk("post_flush_flag", 32'(id_flag), BYP ? 32'h1 : 32'h0);
    idle(1'b0);
    chk("post_flush2_flag", 32'(id_flag), BYP ? 32'h0 : 32'h1);
    idle(1'b0);
    chk("post_flush3_count", 32'(ifq_count), 32'h0);

    // Full with simultaneous push and pop: pop happens, push rejected
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    chk("full2_full", 32'(if_full), 32'h1);
    step(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
    chk("full2_count", 32'(ifq_count), 32'h3);
    chk("full2_pc", id_pc, 32'hE0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("full2_end_flag", 32'(id_flag), 32'h0);
    chk("full2_end_count", 32'(ifq_count), 32'h0);

    // Asynchronous reset mid-stream with count=3 and id_flag=1
    step(1'b1, 32'hD0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hD4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hD8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDC, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk);
    id_stall = 1'b0;
    @(posedge clk);
    #2;
    chk("prerst_count", 32'(ifq_count), 32'h3);
    chk("prerst_flag", 32'(id_flag), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("arst_flag", 32'(id_flag), 32'h0);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_inst", id_inst, 32'h0);
    chk("arst_count", 32'(ifq_count), 32'h0);
    chk("arst_full", 32'(if_full), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("postrst_flag", 32'(id_flag), 32'h0);
    chk("postrst_count", 32'(ifq_count), 32'h0);

    // Every expected entry must have reached ID
    chk("sb_left", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
